// File: rtl/quad_vga_renderer.sv
// VGA timing generator that shows four quadrant colours, latched once per frame so a frame never tears.
// Latency: sync/colour 1 clk, h_pos/v_pos 0 clk. No backpressure: the counters advance on every pix_en.
module quad_vga_renderer #(
    parameter int H_VIS  = 640,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_VIS  = 480,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_en,
    input  logic [23:0] ch0,
    input  logic [23:0] ch1,
    input  logic [23:0] ch2,
    input  logic [23:0] ch3,
    output logic        hsync,
    output logic        vsync,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        frame_start,
    output logic [9:0]  h_pos,
    output logic [9:0]  v_pos
);

    localparam logic [9:0] H_LAST = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] H_ACT  = 10'(H_VIS);
    localparam logic [9:0] V_ACT  = 10'(V_VIS);
    localparam logic [9:0] H_MID  = 10'(H_VIS / 2);
    localparam logic [9:0] V_MID  = 10'(V_VIS / 2);
    localparam logic [9:0] HS_BEG = 10'(H_VIS + H_FP);
    localparam logic [9:0] HS_END = 10'(H_VIS + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG = 10'(V_VIS + V_FP);
    localparam logic [9:0] VS_END = 10'(V_VIS + V_FP + V_SYNC);

    logic [9:0]  h_cnt;
    logic [9:0]  v_cnt;
    logic [23:0] sh0, sh1, sh2, sh3;
    logic        h_wrap;
    logic        frame_wrap;
    logic        left, top, active;
    logic [23:0] sel;
    logic        hsync_nxt, vsync_nxt;
    logic        unused_bits;

    assign h_wrap     = (h_cnt == H_LAST);
    assign frame_wrap = pix_en && h_wrap && (v_cnt == V_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_en) begin
            if (h_wrap) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
            end else begin
                h_cnt <= h_cnt + 10'd1;
            end
        end
    end

    // Colours are captured only at the frame boundary; the value present at that edge is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh0 <= '0;
            sh1 <= '0;
            sh2 <= '0;
            sh3 <= '0;
        end else if (frame_wrap) begin
            sh0 <= ch0;
            sh1 <= ch1;
            sh2 <= ch2;
            sh3 <= ch3;
        end
    end

    always_comb begin
        left      = (h_cnt < H_MID);
        top       = (v_cnt < V_MID);
        active    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
        hsync_nxt = !((h_cnt >= HS_BEG) && (h_cnt < HS_END));
        vsync_nxt = !((v_cnt >= VS_BEG) && (v_cnt < VS_END));
        case ({top, left})
            2'b11:   sel = sh0;
            2'b10:   sel = sh2;
            2'b01:   sel = sh1;
            default: sel = sh3;
        endcase
    end

    // Only the top nibble of each colour reaches the 4-bit DAC.
    assign unused_bits = ^{sel[19:16], sel[11:8], sel[3:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            vga_r       <= 4'h0;
            vga_g       <= 4'h0;
            vga_b       <= 4'h0;
            frame_start <= 1'b0;
        end else begin
            hsync       <= hsync_nxt;
            vsync       <= vsync_nxt;
            vga_r       <= active ? sel[23:20] : 4'h0;
            vga_g       <= active ? sel[15:12] : 4'h0;
            vga_b       <= active ? sel[7:4]   : 4'h0;
            frame_start <= frame_wrap;
        end
    end

    assign h_pos = h_cnt;
    assign v_pos = v_cnt;

endmodule

// File: tb/tb_quad_vga_renderer.sv
// Bench for quad_vga_renderer on a shrunken raster (32x19) so whole frames fit in a short run.
module tb_quad_vga_renderer;

    localparam int H_VIS = 20, H_FP = 3, H_SYNC = 5, H_BP = 4;
    localparam int V_VIS = 12, V_FP = 2, V_SYNC = 2, V_BP = 3;
    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int F_TOT = H_TOT * V_TOT;

    logic        clk = 1'b0;
    logic        rst, pix_en;
    logic [23:0] ch0, ch1, ch2, ch3;
    logic        hsync, vsync, frame_start;
    logic [3:0]  vga_r, vga_g, vga_b;
    logic [9:0]  h_pos, v_pos;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: linear raster index and the four latched colours.
    int          m_idx = 0;
    logic [23:0] m_sh [4];

    typedef struct {
        int         h;
        int         v;
        logic       hs;
        logic       vs;
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } vec_t;
    vec_t tbl [18];

    quad_vga_renderer #(
        .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) dut (
        .clk(clk), .rst(rst), .pix_en(pix_en),
        .ch0(ch0), .ch1(ch1), .ch2(ch2), .ch3(ch3),
        .hsync(hsync), .vsync(vsync),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .frame_start(frame_start), .h_pos(h_pos), .v_pos(v_pos)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Registered outputs {hsync, vsync, r, g, b} produced for raster index idx.
    function automatic logic [13:0] model_out(input int idx);
        int h, v, q;
        logic [23:0] c;
        logic hs, vs;
        h  = idx % H_TOT;
        v  = idx / H_TOT;
        hs = !(h >= H_VIS + H_FP && h < H_VIS + H_FP + H_SYNC);
        vs = !(v >= V_VIS + V_FP && v < V_VIS + V_FP + V_SYNC);
        c  = 24'h0;
        if (h < H_VIS && v < V_VIS) begin
            q = ((h >= H_VIS / 2) ? 2 : 0) + ((v >= V_VIS / 2) ? 1 : 0);
            c = m_sh[q];
        end
        return {hs, vs, c[23:20], c[15:12], c[7:4]};
    endfunction

    task automatic step(input logic r, input logic pe);
        logic [23:0] cap [4];
        logic [13:0] o;
        logic        fs;
        int          nidx;
        rst    = r;
        pix_en = pe;
        cap[0] = ch0; cap[1] = ch1; cap[2] = ch2; cap[3] = ch3;
        if (r) begin
            o    = 14'b11_0000_0000_0000;
            fs   = 1'b0;
            nidx = 0;
        end else begin
            o    = model_out(m_idx);
            fs   = pe && (m_idx == F_TOT - 1);
            nidx = pe ? (m_idx + 1) % F_TOT : m_idx;
        end
        @(posedge clk);
        m_idx = nidx;
        if (r) begin
            for (int i = 0; i < 4; i++) m_sh[i] = 24'h0;
        end else if (fs) begin
            for (int i = 0; i < 4; i++) m_sh[i] = cap[i];
        end
        #1;
        check("cycle", {h_pos, v_pos, hsync, vsync, vga_r, vga_g, vga_b, frame_start},
              {10'(nidx % H_TOT), 10'(nidx / H_TOT), o, fs});
    endtask

    task automatic walk_to(input int th, input int tv);
        bit hit;
        hit = 1'b0;
        for (int k = 0; k < 2 * F_TOT; k++) begin
            if (h_pos == 10'(th) && v_pos == 10'(tv)) begin
                hit = 1'b1;
                break;
            end
            step(1'b0, 1'b1);
        end
        if (!hit) check("walk_timeout", {h_pos, v_pos}, {10'(th), 10'(tv)});
    endtask

    task automatic look(input string name, input logic [3:0] r, input logic [3:0] g, input logic [3:0] b);
        step(1'b0, 1'b1);
        check(name, {vga_r, vga_g, vga_b}, {r, g, b});
    endtask

    task automatic measure_period(input int div, output int cnt);
        bit seen;
        int ph;
        ph   = 0;
        cnt  = 0;
        seen = 1'b0;
        for (int k = 0; k < 2 * div * F_TOT && !seen; k++) begin
            step(1'b0, (ph % div) == 0);
            ph++;
            seen = frame_start;
        end
        seen = 1'b0;
        for (int k = 0; k < 2 * div * F_TOT && !seen; k++) begin
            step(1'b0, (ph % div) == 0);
            ph++;
            cnt++;
            seen = frame_start;
        end
    endtask

    initial begin
        int per, hs_run, hs_max, vs_run, vs_max;

        tbl[0]  = '{1,  1,  1'b1, 1'b1, 4'hF, 4'h0, 4'h0};
        tbl[1]  = '{9,  1,  1'b1, 1'b1, 4'hF, 4'h0, 4'h0};
        tbl[2]  = '{10, 1,  1'b1, 1'b1, 4'h0, 4'h0, 4'hF};
        tbl[3]  = '{11, 1,  1'b1, 1'b1, 4'h0, 4'h0, 4'hF};
        tbl[4]  = '{1,  5,  1'b1, 1'b1, 4'hF, 4'h0, 4'h0};
        tbl[5]  = '{1,  6,  1'b1, 1'b1, 4'h0, 4'hF, 4'h0};
        tbl[6]  = '{1,  7,  1'b1, 1'b1, 4'h0, 4'hF, 4'h0};
        tbl[7]  = '{11, 7,  1'b1, 1'b1, 4'hF, 4'hF, 4'h0};
        tbl[8]  = '{19, 11, 1'b1, 1'b1, 4'hF, 4'hF, 4'h0};
        tbl[9]  = '{20, 11, 1'b1, 1'b1, 4'h0, 4'h0, 4'h0};
        tbl[10] = '{22, 11, 1'b1, 1'b1, 4'h0, 4'h0, 4'h0};
        tbl[11] = '{23, 11, 1'b0, 1'b1, 4'h0, 4'h0, 4'h0};
        tbl[12] = '{27, 11, 1'b0, 1'b1, 4'h0, 4'h0, 4'h0};
        tbl[13] = '{28, 11, 1'b1, 1'b1, 4'h0, 4'h0, 4'h0};
        tbl[14] = '{20, 12, 1'b1, 1'b1, 4'h0, 4'h0, 4'h0};
        tbl[15] = '{0,  14, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0};
        tbl[16] = '{24, 15, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0};
        tbl[17] = '{0,  16, 1'b1, 1'b1, 4'h0, 4'h0, 4'h0};

        for (int i = 0; i < 4; i++) m_sh[i] = 24'h0;
        rst = 1'b1; pix_en = 1'b0;
        ch0 = 24'h0; ch1 = 24'h0; ch2 = 24'h0; ch3 = 24'h0;

        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        check("reset_state", {h_pos, v_pos, hsync, vsync, vga_r, vga_g, vga_b, frame_start},
              {10'd0, 10'd0, 1'b1, 1'b1, 12'h000, 1'b0});

        // Frame 1 stays black; the colours appear after the first wrap.
        ch0 = 24'hFF0000; ch1 = 24'h00FF00; ch2 = 24'h0000FF; ch3 = 24'hFFFF00;
        for (int k = 0; k < F_TOT; k++) step(1'b0, 1'b1);
        check("first_wrap_fs", {frame_start, h_pos, v_pos}, {1'b1, 10'd0, 10'd0});

        for (int i = 0; i < 18; i++) begin
            walk_to(tbl[i].h, tbl[i].v);
            step(1'b0, 1'b1);
            check($sformatf("tbl%0d", i), {hsync, vsync, vga_r, vga_g, vga_b},
                  {tbl[i].hs, tbl[i].vs, tbl[i].r, tbl[i].g, tbl[i].b});
        end

        measure_period(1, per);
        check("period_div1", per, F_TOT);
        measure_period(4, per);
        check("period_div4", per, 4 * F_TOT);

        walk_to(0, 0);
        hs_run = 0; hs_max = 0; vs_run = 0; vs_max = 0;
        for (int k = 0; k < F_TOT; k++) begin
            step(1'b0, 1'b1);
            hs_run = hsync ? 0 : hs_run + 1;
            vs_run = vsync ? 0 : vs_run + 1;
            if (hs_run > hs_max) hs_max = hs_run;
            if (vs_run > vs_max) vs_max = vs_run;
        end
        check("hsync_width", hs_max, H_SYNC);
        check("vsync_width", vs_max, V_SYNC * H_TOT);

        // Mid-frame colour change must wait for the next frame.
        walk_to(0, 3);
        ch0 = 24'h00FFFF;
        walk_to(2, 4);
        look("ch0_hold", 4'hF, 4'h0, 4'h0);
        walk_to(2, 2);
        look("ch0_next", 4'h0, 4'hF, 4'hF);

        // A change right after the wrap edge misses this frame.
        walk_to(H_TOT - 1, V_TOT - 1);
        ch1 = 24'h9ABCDE;
        step(1'b0, 1'b1);
        check("wrap_fs", frame_start, 1'b1);
        ch1 = 24'h111111;
        walk_to(1, 7);
        look("wrap_sample", 4'h9, 4'hB, 4'hD);

        walk_to(15, 8);
        step(1'b1, 1'b1);
        check("mid_reset", {h_pos, v_pos, hsync, vsync, vga_r, vga_g, vga_b},
              {10'd0, 10'd0, 1'b1, 1'b1, 12'h000});

        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 7) == 0) begin
                ch0 = 24'($urandom); ch1 = 24'($urandom);
                ch2 = 24'($urandom); ch3 = 24'($urandom);
            end
            step($urandom_range(0, 799) == 0, $urandom_range(0, 2) != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/quad_vga_renderer.md
QUAD_VGA_RENDERER -- requirements
Module: quad_vga_renderer

Interface
REQ-001 Parameters SHALL be (name, default, meaning): H_VIS 640 visible pixels per line; H_FP 16 front porch; H_SYNC 96 sync width; H_BP 48 back porch; V_VIS 480 visible lines; V_FP 10; V_SYNC 2; V_BP 33.
REQ-002 clk  input  1  system clock; the design SHALL use one clock, rising edge only.
REQ-003 rst  input  1  reset; the block SHALL use a synchronous, active-high reset.
REQ-004 pix_en  input  1  pixel-rate enable, e.g. 1 clk in 4 at 100 MHz.
REQ-005 ch0, ch1, ch2, ch3  input  24 each  quadrant colours {R[23:16],G[15:8],B[7:0]}, driven by the colour processor.
REQ-006 hsync, vsync  output  1 each  active-low sync pulses.
REQ-007 vga_r, vga_g, vga_b  output  4 each  pixel colour.
REQ-008 frame_start  output  1  one-clk pulse at the start of each frame.
REQ-009 h_pos, v_pos  output  10 each  current counter values.

Function
REQ-010 The block SHALL keep a 10-bit h_cnt, range 0..H_TOT-1 with H_TOT=H_VIS+H_FP+H_SYNC+H_BP=800, and a 10-bit v_cnt, range 0..V_TOT-1 with V_TOT=525.
REQ-011 Counters SHALL change only on clk edges with pix_en=1; with pix_en=0 all state except the frame_start clear SHALL hold.
REQ-012 On pix_en, h_cnt SHALL increment; at H_TOT-1 it SHALL wrap to 0 and v_cnt SHALL increment; at v_cnt=V_TOT-1 with h_cnt=H_TOT-1, v_cnt SHALL wrap to 0.
REQ-013 Shadow registers sh0..sh3 (24 bits each) SHALL load ch0..ch3 only on the pix_en edge where both counters wrap (799,524 -> 0,0); no other edge SHALL change them, so no tearing occurs mid-frame.
REQ-014 frame_start SHALL be 1 for exactly the single clk following the wrap edge of REQ-013, otherwise 0.
REQ-015 Active region SHALL be h_cnt<H_VIS and v_cnt<V_VIS.
REQ-016 Quadrant mapping SHALL be as follows, with left = h_cnt<H_VIS/2 and top = v_cnt<V_VIS/2: top-left sh0; top-right sh2; bottom-left sh1; bottom-right sh3.
REQ-017 vga_r/g/b SHALL be the upper nibbles [23:20], [15:12], [7:4] of the selected shadow in the active region, and 0 outside it.
REQ-018 hsync SHALL be 0 iff H_VIS+H_FP <= h_cnt < H_VIS+H_FP+H_SYNC (656..751).
REQ-019 vsync SHALL be 0 iff V_VIS+V_FP <= v_cnt < V_VIS+V_FP+V_SYNC (490..491).
REQ-020 hsync, vsync, vga_r/g/b SHALL be registered, updating every clk from the current counters and shadows (1 clk latency); sync and colour SHALL therefore stay mutually aligned.
REQ-021 h_pos/v_pos SHALL equal h_cnt/v_cnt directly (0 latency).
REQ-022 ch0..ch3 changes SHALL be ignored until the next frame wrap, including changes on the wrap edge itself, where the value sampled is the pre-edge input.

Reset
REQ-023 While rst=1 at a clk edge: h_cnt=0, v_cnt=0, sh0..sh3=0, hsync=1, vsync=1, vga_r/g/b=0, frame_start=0.
REQ-024 rst SHALL have priority over pix_en; reset asserted mid-frame SHALL restart at (0,0) on the next edge.
REQ-025 After reset the first frame SHALL be black, since the shadows are 0; ch inputs SHALL first appear after the first wrap.

Verification
REQ-026 Reset, then pix_en=1 every clk with ch0=FF0000, ch1=00FF00, ch2=0000FF, ch3=FFFF00 held -> frame 1 all black; frame 2 at (10,10) R=F,G=0,B=0; at (330,10) B=F; at (10,250) G=F; at (330,250) R=F,G=F,B=0.
REQ-027 Count edges from one frame_start to the next with pix_en=1 always -> exactly 420000; hsync low for 96 consecutive pix_en steps per line; vsync low for 2 lines (1600 steps).
REQ-028 pix_en 1-in-4 -> frame_start period 1680000 clk; outputs constant across each 4-clk pixel.
REQ-029 Change ch0 to 00FFFF at v_cnt=100 -> top-left unchanged for the rest of the frame, shows G=F,B=F from the next frame.
REQ-030 Assert rst for 1 clk at (400,300) -> next edge h_pos=0, v_pos=0, outputs black, hsync=vsync=1.
REQ-031 At (639,479) and (640,480) -> colour nonzero at the first, 0 at the second; boundaries 319/320 and 239/240 switch quadrant.
